lcd_msg_scheduler: RTL and testbench

- Decides which screen the LCD character driver renders: blank, urgent banner, a rotating warning, or the default ODO/FUEL page.
- Arbitrates N_REQ message requesters. Enforces a minimum readable dwell time per warning.
- Hands each new selection to the LCD driver with a req/ack handshake so the driver reloads its line buffers and rewrites the panel.
- Sits between the vehicle status logic (engine, key, side brake, low fuel) and the LCD driver.

---
 rtl/lcd_msg_scheduler.sv | 127 ++++++++++++
 tb/tb_lcd_msg_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_scheduler.sv
// Chooses the LCD screen (blank / urgent / rotating warning / default page),
// enforces a minimum dwell per warning and flags each new selection to the driver.
module lcd_msg_scheduler #(
  parameter int N_REQ     = 4,
  parameter int DWELL_CYC = 50_000_000,
  parameter int CW        = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blank,
  input  logic [N_REQ-1:0] req,
  input  logic             upd_ack,
  output logic [3:0]       msg_sel,
  output logic             upd_req,
  output logic             dwell_busy
);

  typedef enum logic [1:0] {S_BLANK, S_URGENT, S_SHOW, S_DEFAULT} state_t;

  localparam logic [3:0]    ID_BLANK   = 4'hF;
  localparam logic [3:0]    ID_URGENT  = 4'd0;
  localparam logic [3:0]    ID_DEFAULT = 4'(N_REQ);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);

  // Successor of a normal index, wrapping over 1..N_REQ-1.
  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (i >= 4'(N_REQ - 1)) ? 4'd1 : i + 4'd1;
  endfunction

  // First set bit of v at or after start, wrapping over 1..N_REQ-1.
  // Returns {found, index}; the upper segment is scanned last so it wins.
  function automatic logic [4:0] pick(input logic [N_REQ-1:0] v, input logic [3:0] start);
    logic       found;
    logic [3:0] idx;
    found = 1'b0;
    idx   = 4'd0;
    for (int j = N_REQ - 1; j >= 1; j--) begin
      if (v[j] && (4'(j) < start)) begin
        found = 1'b1;
        idx   = 4'(j);
      end
    end
    for (int j = N_REQ - 1; j >= 1; j--) begin
      if (v[j] && (4'(j) >= start)) begin
        found = 1'b1;
        idx   = 4'(j);
      end
    end
    return {found, idx};
  endfunction

  state_t           state, state_n;
  logic [3:0]       sel_n;
  logic [3:0]       rr_ptr, rr_n;
  logic [CW-1:0]    dwell_cnt, cnt_n;
  logic             upd_n, busy_n;
  logic [N_REQ-1:0] normal, others;
  logic             own;
  logic [4:0]       hit_rr, hit_next;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    normal    = req;
    normal[0] = 1'b0;
    others    = normal;
    own       = 1'b0;
    for (int j = 1; j < N_REQ; j++) begin
      if (4'(j) == msg_sel) begin
        own       = req[j];
        others[j] = 1'b0;
      end
    end
    hit_rr   = pick(normal, rr_ptr);
    hit_next = pick(others, next_idx(msg_sel));

    state_n = state;
    sel_n   = msg_sel;
    cnt_n   = '0;
    rr_n    = rr_ptr;

    // Priority: blank, urgent, dwell hold, rotation, default page.
    if (blank) begin
      state_n = S_BLANK;
      sel_n   = ID_BLANK;
    end else if (req[0]) begin
      state_n = S_URGENT;
      sel_n   = ID_URGENT;
    end else if (state == S_SHOW && dwell_cnt != DWELL_LAST) begin
      cnt_n = dwell_cnt + 1'b1;
    end else if (state == S_SHOW && hit_next[4]) begin
      sel_n = hit_next[3:0];
      rr_n  = next_idx(hit_next[3:0]);
    end else if (state == S_SHOW && own) begin
      sel_n = msg_sel;
    end else if (state != S_SHOW && hit_rr[4]) begin
      state_n = S_SHOW;
      sel_n   = hit_rr[3:0];
    end else begin
      state_n = S_DEFAULT;
      sel_n   = ID_DEFAULT;
    end

    busy_n = (state_n == S_SHOW) && (cnt_n != DWELL_LAST);
    // A new ID always (re)raises the request, even against a same-cycle ack.
    upd_n  = (sel_n != msg_sel) || (upd_req && !upd_ack);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BLANK;
      msg_sel    <= ID_BLANK;
      upd_req    <= 1'b0;
      dwell_busy <= 1'b0;
      dwell_cnt  <= '0;
      rr_ptr     <= 4'd1;
    end else begin
      state      <= state_n;
      msg_sel    <= sel_n;
      upd_req    <= upd_n;
      dwell_busy <= busy_n;
      dwell_cnt  <= cnt_n;
      rr_ptr     <= rr_n;
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed and randomized checks of lcd_msg_scheduler against a screen-level
// reference model (N_REQ=4, DWELL_CYC=10).
module tb_lcd_msg_scheduler;

  localparam int N  = 4;
  localparam int D  = 10;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         blank;
  logic [N-1:0] req;
  logic         upd_ack;
  logic [3:0]   msg_sel;
  logic         upd_req;
  logic         dwell_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: current screen ID, cycles it has been shown, rotation pointer.
  int m_sel, m_age, m_rr;
  bit m_upd, m_busy;

  lcd_msg_scheduler #(.N_REQ(N), .DWELL_CYC(D), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .blank      (blank),
    .req        (req),
    .upd_ack    (upd_ack),
    .msg_sel    (msg_sel),
    .upd_req    (upd_req),
    .dwell_busy (dwell_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First pending normal index visiting from, from+1, ... with wrap, skipping skip.
  function automatic int search(input int rv, input int from, input int skip);
    for (int i = 0; i < N - 1; i++) begin
      int c;
      c = ((from - 1 + i) % (N - 1)) + 1;
      if (c != skip && ((rv >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  function automatic bit is_warning(input int id);
    return id >= 1 && id <= N - 1;
  endfunction

  task automatic model_step(input bit b, input logic [N-1:0] r, input bit a);
    int prev, rv, c;
    prev = m_sel;
    rv   = int'(r);
    if (b) begin
      m_sel = 15; m_age = 0;
    end else if ((rv & 1) == 1) begin
      m_sel = 0; m_age = 0;
    end else if (is_warning(m_sel) && m_age < D - 1) begin
      m_age++;
    end else if (is_warning(m_sel)) begin
      c = search(rv, (m_sel % (N - 1)) + 1, m_sel);
      m_age = 0;
      if (c > 0) begin
        m_sel = c;
        m_rr  = (c % (N - 1)) + 1;
      end else if (((rv >> m_sel) & 1) == 0) begin
        m_sel = N;
      end
    end else begin
      c = search(rv, m_rr, -1);
      m_sel = (c > 0) ? c : N;
      m_age = 0;
    end
    m_upd  = (m_sel != prev) || (m_upd && !a);
    m_busy = is_warning(m_sel) && m_age < D - 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(blank, req, upd_ack);
    #1;
    check("msg_sel", 32'(msg_sel), 32'(m_sel));
    check("upd_req", 32'(upd_req), 32'(m_upd));
    check("dwell_busy", 32'(dwell_busy), 32'(m_busy));
  endtask

  initial begin
    rst = 1'b1; blank = 1'b1; req = '0; upd_ack = 1'b0;
    m_sel = 15; m_age = 0; m_rr = 1; m_upd = 1'b0; m_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 32'(msg_sel), 32'hF);
    check("reset_upd", 32'(upd_req), 0);
    check("reset_busy", 32'(dwell_busy), 0);
    rst = 1'b0;
    tick(); tick();
    check("blank_hold_sel", 32'(msg_sel), 32'hF);

    // Leave blank: default page, then acknowledge.
    blank = 1'b0;
    tick();
    check("default_sel", 32'(msg_sel), 4);
    check("default_upd", 32'(upd_req), 1);
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    check("ack_clears", 32'(upd_req), 0);

    // Two warnings rotate with full dwell each.
    req = 4'b0110;
    tick();
    check("rot_first", 32'(msg_sel), 1);
    check("rot_busy", 32'(dwell_busy), 1);
    repeat (9) tick();
    check("rot_hold", 32'(msg_sel), 1);
    check("rot_busy_end", 32'(dwell_busy), 0);
    tick();
    check("rot_second", 32'(msg_sel), 2);
    check("rot_upd", 32'(upd_req), 1);
    repeat (10) tick();
    check("rot_wrap", 32'(msg_sel), 1);

    // Short request still gets its full dwell.
    req = '0;
    repeat (12) tick();
    check("idle_default", 32'(msg_sel), 4);
    req = 4'b0010;
    tick(); tick();
    req = '0;
    repeat (8) tick();
    check("short_held", 32'(msg_sel), 1);
    tick();
    check("short_release", 32'(msg_sel), 4);

    // Urgent preempts mid-dwell; interrupted warning restarts its dwell.
    req = 4'b0100;
    tick();
    repeat (5) tick();
    req = 4'b0101;
    tick();
    check("urgent_preempt", 32'(msg_sel), 0);
    check("urgent_busy", 32'(dwell_busy), 0);
    req = 4'b0100;
    tick();
    check("urgent_return", 32'(msg_sel), 2);
    check("urgent_restart", 32'(dwell_busy), 1);
    repeat (9) tick();

    // Blank overrides urgent and hands back to it.
    req = 4'b0001;
    tick();
    check("urgent_sel", 32'(msg_sel), 0);
    blank = 1'b1; tick();
    check("blank_over_urgent", 32'(msg_sel), 32'hF);
    blank = 1'b0; tick();
    check("urgent_after_blank", 32'(msg_sel), 0);

    // Ack coinciding with a change keeps upd_req; stray ack is ignored.
    req = 4'b0110;
    tick();
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    check("ack_clear2", 32'(upd_req), 0);
    repeat (8) tick();
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    check("coalesce_upd", 32'(upd_req), 1);
    check("coalesce_sel", 32'(msg_sel), 1);
    tick();
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    check("late_ack", 32'(upd_req), 0);
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    check("stray_ack", 32'(upd_req), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        req    = 4'($urandom_range(0, 15));
        req[0] = ($urandom_range(0, 9) == 0);
      end
      blank   = ($urandom_range(0, 63) == 0);
      upd_ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
